// File: rtl/assoc_wb_cache_if.sv
// Bus bundle for assoc_wb_cache: the CPU-side request/response signals and the
// word-serial memory-side request/ready signals.
//   slave  : the cache's view (CPU request and memory response in, the rest out)
//   master : the environment's view (CPU driver plus memory responder)
interface assoc_wb_cache_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_read;
  logic              cpu_write;
  logic [DATA_W-1:0] cpu_write_data;
  logic [DATA_W-1:0] cpu_read_data;
  logic              cpu_stall;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;
  logic              mem_ready;

  modport slave (
    input  cpu_address, cpu_read, cpu_write, cpu_write_data, mem_read_data, mem_ready,
    output cpu_read_data, cpu_stall, mem_address, mem_read, mem_write, mem_write_data
  );

  modport master (
    output cpu_address, cpu_read, cpu_write, cpu_write_data, mem_read_data, mem_ready,
    input  cpu_read_data, cpu_stall, mem_address, mem_read, mem_write, mem_write_data
  );
endinterface

// File: rtl/assoc_wb_cache.sv
// assoc_wb_cache: N-way set-associative, write-back / write-allocate cache with
// multi-word lines and per-set round-robin replacement. Memory traffic is
// word-serial: one beat per mem_ready pulse.
// Ports:
//   clk  - sole clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - assoc_wb_cache_if.slave: cpu_address/read/write/write_data in,
//          cpu_read_data/cpu_stall out; mem_address/read/write/write_data out,
//          mem_read_data/mem_ready in
module assoc_wb_cache #(
  parameter int WAYS           = 2,
  parameter int SETS           = 64,
  parameter int WORDS_PER_LINE = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32
) (
  input logic             clk,
  input logic             rst,
  assoc_wb_cache_if.slave bus
);
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = $clog2(WAYS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_e;

  state_e                    state_q;
  logic [TAG_W-1:0]          tag_q  [WAYS][SETS];
  logic [DATA_W-1:0]         data_q [WAYS][SETS][WORDS_PER_LINE];
  logic [WAYS-1:0][SETS-1:0] valid_q;
  logic [WAYS-1:0][SETS-1:0] dirty_q;
  logic [SETS-1:0][WAY_W-1:0] rr_q;
  logic [OFF_W-1:0]          beat_q;
  logic [WAY_W-1:0]          victim_q;
  logic                      mem_read_q;
  logic                      mem_write_q;
  logic [ADDR_W-1:0]         mem_addr_q;
  logic [DATA_W-1:0]         mem_wdata_q;

  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;
  logic             req;
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic [WAY_W-1:0] victim_d;
  logic             inval_found;
  logic [OFF_W-1:0] beat_nxt;
  logic             write_hit;
  logic             read_hit;
  logic             refill_done;

  assign {tag, idx, off} = bus.cpu_address;
  assign req         = bus.cpu_read | bus.cpu_write;
  assign beat_nxt    = beat_q + OFF_W'(1);
  assign write_hit   = (state_q == IDLE) & bus.cpu_write & hit;
  assign read_hit    = (state_q == IDLE) & bus.cpu_read & ~bus.cpu_write & hit;
  assign refill_done = (state_q == REFILL) & bus.mem_ready & (beat_q == LAST_BEAT);

  // Tag lookup across all ways of the indexed set; tags are unique per set.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w][idx] && (tag_q[w][idx] == tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Fill empty ways first (lowest index wins); only fall back to round-robin
  // once the set is full.
  always_comb begin
    victim_d    = rr_q[idx];
    inval_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!inval_found && !valid_q[w][idx]) begin
        victim_d    = WAY_W'(w);
        inval_found = 1'b1;
      end
    end
  end

  assign bus.cpu_stall      = (state_q != IDLE) | (req & ~hit);
  assign bus.cpu_read_data  = read_hit ? data_q[hit_way][idx][off] : '0;
  assign bus.mem_read       = mem_read_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.mem_address    = mem_addr_q;
  assign bus.mem_write_data = mem_wdata_q;

  // Storage arrays carry no reset; valid_q gates everything read from them.
  always_ff @(posedge clk) begin
    if (write_hit) begin
      data_q[hit_way][idx][off] <= bus.cpu_write_data;
    end
    if ((state_q == REFILL) && bus.mem_ready) begin
      data_q[victim_q][idx][beat_q] <= bus.mem_read_data;
    end
    if (refill_done) begin
      tag_q[victim_q][idx] <= tag;
    end
  end

  // Control FSM. Memory-side outputs are registered, so each transition
  // preloads the address/data of the beat that the next state presents.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      dirty_q     <= '0;
      rr_q        <= '0;
      beat_q      <= '0;
      victim_q    <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (write_hit) begin
            dirty_q[hit_way][idx] <= 1'b1;
          end else if (req && !hit) begin
            victim_q <= victim_d;
            beat_q   <= '0;
            if (valid_q[victim_d][idx] && dirty_q[victim_d][idx]) begin
              state_q     <= WRITEBACK;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {tag_q[victim_d][idx], idx, {OFF_W{1'b0}}};
              mem_wdata_q <= data_q[victim_d][idx][0];
            end else begin
              state_q    <= REFILL;
              mem_read_q <= 1'b1;
              mem_addr_q <= {tag, idx, {OFF_W{1'b0}}};
            end
          end
        end
        WRITEBACK: begin
          if (bus.mem_ready) begin
            beat_q <= beat_nxt;
            if (beat_q == LAST_BEAT) begin
              state_q     <= REFILL;
              mem_write_q <= 1'b0;
              mem_read_q  <= 1'b1;
              mem_addr_q  <= {tag, idx, {OFF_W{1'b0}}};
            end else begin
              mem_addr_q  <= {tag_q[victim_q][idx], idx, beat_nxt};
              mem_wdata_q <= data_q[victim_q][idx][beat_nxt];
            end
          end
        end
        REFILL: begin
          if (bus.mem_ready) begin
            beat_q <= beat_nxt;
            if (beat_q == LAST_BEAT) begin
              state_q                <= IDLE;
              mem_read_q             <= 1'b0;
              valid_q[victim_q][idx] <= 1'b1;
              dirty_q[victim_q][idx] <= 1'b0;
              rr_q[idx]              <= WAY_W'((int'(victim_q) + 1) % WAYS);
            end else begin
              mem_addr_q <= {tag, idx, beat_nxt};
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          mem_read_q  <= 1'b0;
          mem_write_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_assoc_wb_cache.sv
module tb_assoc_wb_cache;
  localparam int WPL   = 4;
  localparam int NWAYS = 2;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  assoc_wb_cache_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  assoc_wb_cache #(
    .WAYS(2), .SETS(64), .WORDS_PER_LINE(4), .ADDR_W(32), .DATA_W(32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Backing memory (what main memory holds) and the architectural view
  // (latest value the CPU stored at each word address).
  logic [31:0] mem_m  [4096];
  logic [31:0] golden [4096];

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
  } beat_t;
  beat_t beat_log[$];

  int lat_max  = 0;
  int rcnt     = 0;
  int both_cnt = 0;

  // Memory responder: acts on the negative edge, pulses mem_ready for one
  // cycle after 0..lat_max wait cycles, and logs every completed beat.
  always @(negedge clk) begin
    if (bus.mem_read && bus.mem_write) both_cnt++;
    if ((bus.mem_read || bus.mem_write) && !rst) begin
      if (rcnt == 0) begin
        beat_t b;
        bus.mem_ready = 1'b1;
        if (bus.mem_write) mem_m[bus.mem_address[11:0]] = bus.mem_write_data;
        bus.mem_read_data = bus.mem_read ? mem_m[bus.mem_address[11:0]] : 32'h0;
        b.w = bus.mem_write;
        b.a = bus.mem_address;
        b.d = bus.mem_write_data;
        beat_log.push_back(b);
        rcnt = $urandom_range(lat_max, 0);
      end else begin
        bus.mem_ready = 1'b0;
        rcnt--;
      end
    end else begin
      bus.mem_ready     = 1'b0;
      bus.mem_read_data = 32'h0;
    end
  end

  // Residency model for the randomized phase (4 sets exercised).
  bit m_valid [NWAYS][4];
  bit m_dirty [NWAYS][4];
  int m_tag   [NWAYS][4];
  int m_rr    [4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4096; i++) golden[i] = mem_m[i];
    for (int w = 0; w < NWAYS; w++)
      for (int s = 0; s < 4; s++) begin
        m_valid[w][s] = 0;
        m_dirty[w][s] = 0;
        m_tag[w][s]   = 0;
      end
    for (int s = 0; s < 4; s++) m_rr[s] = 0;
  endtask

  // One CPU access: checks first-cycle stall, final read data, and the exact
  // sequence of memory beats (write-back of the victim line, then refill).
  task automatic do_op(input logic [31:0] a, input bit rd, input bit wr, input logic [31:0] wd,
                       input bit exp_hit, input logic [31:0] exp_rd, input bit exp_wb,
                       input logic [31:0] wb_base, input string nm);
    int n;
    int nwb;
    int nrf;
    logic [31:0] line;
    @(posedge clk); #1;
    beat_log.delete();
    bus.cpu_address    = a;
    bus.cpu_read       = rd;
    bus.cpu_write      = wr;
    bus.cpu_write_data = wd;
    @(negedge clk);
    check($sformatf("%s@%h stall_first", nm, a), 32'(bus.cpu_stall), 32'(!exp_hit));
    n = 0;
    while (bus.cpu_stall && n < 400) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("%s@%h stall_release", nm, a), 32'(bus.cpu_stall), 32'h0);
    check($sformatf("%s@%h rdata", nm, a), bus.cpu_read_data, exp_rd);
    check($sformatf("%s@%h mem_idle", nm, a), {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
    line = {a[31:2], 2'b00};
    nwb  = exp_wb ? WPL : 0;
    nrf  = exp_hit ? 0 : WPL;
    check($sformatf("%s@%h beats", nm, a), 32'(beat_log.size()), 32'(nwb + nrf));
    if (beat_log.size() == nwb + nrf) begin
      for (int i = 0; i < nwb + nrf; i++) begin
        if (i < nwb) begin
          check($sformatf("%s@%h wb%0d kind", nm, a, i), 32'(beat_log[i].w), 32'h1);
          check($sformatf("%s@%h wb%0d addr", nm, a, i), beat_log[i].a, wb_base + 32'(i));
          check($sformatf("%s@%h wb%0d data", nm, a, i), beat_log[i].d,
                golden[(wb_base[11:0] + 12'(i))]);
        end else begin
          check($sformatf("%s@%h rf%0d kind", nm, a, i), 32'(beat_log[i].w), 32'h0);
          check($sformatf("%s@%h rf%0d addr", nm, a, i), beat_log[i].a, line + 32'(i - nwb));
        end
      end
    end
    @(posedge clk); #1;
    bus.cpu_read  = 1'b0;
    bus.cpu_write = 1'b0;
    if (wr) golden[a[11:0]] = wd;
  endtask

  task automatic rand_op();
    int t, s, o, r, v;
    bit rd, wr, hit, wb;
    logic [31:0] a, wd, wbb, exp;
    t  = $urandom_range(3, 0);
    s  = $urandom_range(3, 0);
    o  = $urandom_range(3, 0);
    a  = 32'((t << 8) | (s << 2) | o);
    r  = $urandom_range(7, 0);
    rd = (r < 4) || (r == 7);
    wr = (r >= 4);
    wd = $urandom;
    hit = 0;
    v   = -1;
    for (int w = 0; w < NWAYS; w++)
      if (m_valid[w][s] && m_tag[w][s] == t) begin
        hit = 1;
        v   = w;
      end
    wb  = 0;
    wbb = 32'h0;
    if (!hit) begin
      for (int w = 0; w < NWAYS; w++)
        if (v < 0 && !m_valid[w][s]) v = w;
      if (v < 0) v = m_rr[s];
      if (m_valid[v][s] && m_dirty[v][s]) begin
        wb  = 1;
        wbb = 32'((m_tag[v][s] << 8) | (s << 2));
      end
    end
    exp = wr ? 32'h0 : golden[a[11:0]];
    do_op(a, rd, wr, wd, hit, exp, wb, wbb, "rand");
    if (!hit) begin
      m_valid[v][s] = 1;
      m_tag[v][s]   = t;
      m_dirty[v][s] = 0;
      m_rr[s]       = (v + 1) % NWAYS;
    end
    if (wr) m_dirty[v][s] = 1;
  endtask

  typedef struct {
    logic [31:0] addr;
    bit          rd;
    bit          wr;
    logic [31:0] wd;
    bit          hit;
    logic [31:0] rdata;
    bit          wb;
    logic [31:0] wb_base;
  } vec_t;

  initial begin
    vec_t tbl[$];
    int   n;
    for (int i = 0; i < 4096; i++) begin
      mem_m[i]  = 32'hA5A5_0000 | 32'(i);
      golden[i] = mem_m[i];
    end
    rst                = 1'b1;
    bus.cpu_address    = 32'h0;
    bus.cpu_read       = 1'b0;
    bus.cpu_write      = 1'b0;
    bus.cpu_write_data = 32'h0;

    tbl.push_back('{32'h040, 1, 0, 32'h0,        0, 32'hA5A5_0040, 0, 32'h0});
    tbl.push_back('{32'h042, 1, 0, 32'h0,        1, 32'hA5A5_0042, 0, 32'h0});
    tbl.push_back('{32'h041, 0, 1, 32'hDEADBEEF, 1, 32'h0,         0, 32'h0});
    tbl.push_back('{32'h041, 1, 0, 32'h0,        1, 32'hDEADBEEF, 0, 32'h0});
    tbl.push_back('{32'h140, 1, 0, 32'h0,        0, 32'hA5A5_0140, 0, 32'h0});
    tbl.push_back('{32'h040, 1, 0, 32'h0,        1, 32'hA5A5_0040, 0, 32'h0});
    tbl.push_back('{32'h240, 1, 0, 32'h0,        0, 32'hA5A5_0240, 1, 32'h040});
    tbl.push_back('{32'h041, 1, 0, 32'h0,        0, 32'hDEADBEEF, 0, 32'h0});
    tbl.push_back('{32'h300, 0, 1, 32'h12345678, 0, 32'h0,         0, 32'h0});
    tbl.push_back('{32'h300, 1, 0, 32'h0,        1, 32'h12345678, 0, 32'h0});
    tbl.push_back('{32'h302, 1, 1, 32'h5555AAAA, 1, 32'h0,         0, 32'h0});
    tbl.push_back('{32'h302, 1, 0, 32'h0,        1, 32'h5555AAAA, 0, 32'h0});
    tbl.push_back('{32'h400, 1, 0, 32'h0,        0, 32'hA5A5_0400, 0, 32'h0});
    tbl.push_back('{32'h500, 1, 0, 32'h0,        0, 32'hA5A5_0500, 1, 32'h300});
    tbl.push_back('{32'h301, 1, 0, 32'h0,        0, 32'hA5A5_0301, 0, 32'h0});
    tbl.push_back('{32'h302, 1, 0, 32'h0,        1, 32'h5555AAAA, 0, 32'h0});

    do_reset();
    @(negedge clk);
    check("reset stall", 32'(bus.cpu_stall), 32'h0);
    check("reset rdata", bus.cpu_read_data, 32'h0);
    check("reset mem_read", 32'(bus.mem_read), 32'h0);
    check("reset mem_write", 32'(bus.mem_write), 32'h0);
    check("reset mem_address", bus.mem_address, 32'h0);
    check("reset mem_write_data", bus.mem_write_data, 32'h0);

    lat_max = 0;
    foreach (tbl[i])
      do_op(tbl[i].addr, tbl[i].rd, tbl[i].wr, tbl[i].wd, tbl[i].hit, tbl[i].rdata,
            tbl[i].wb, tbl[i].wb_base, $sformatf("vec%0d", i));

    // Reset two beats into a refill: the refill aborts and nothing installs.
    @(posedge clk); #1;
    beat_log.delete();
    bus.cpu_address = 32'h080;
    bus.cpu_read    = 1'b1;
    n = 0;
    while (beat_log.size() < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("midrst beats_before_reset", 32'(beat_log.size()), 32'h2);
    @(posedge clk); #1;
    rst          = 1'b1;
    bus.cpu_read = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst mem_read", 32'(bus.mem_read), 32'h0);
    check("midrst mem_write", 32'(bus.mem_write), 32'h0);
    check("midrst stall", 32'(bus.cpu_stall), 32'h0);
    check("midrst rdata", bus.cpu_read_data, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4096; i++) golden[i] = mem_m[i];
    do_op(32'h080, 1, 0, 32'h0, 0, golden[12'h080], 0, 32'h0, "midrst_reread");
    do_op(32'h081, 1, 0, 32'h0, 1, golden[12'h081], 0, 32'h0, "midrst_hit");

    do_reset();
    lat_max = 2;
    for (int i = 0; i < 300; i++) rand_op();

    check("rd_wr_exclusive", 32'(both_cnt), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
